// File: rtl/rotary_quadrature_filter.sv
// Rotary encoder front end: per-channel synchroniser and debounce filter, then a
// quadrature decoder that emits one step pulse per detent and counts illegal moves.
module rotary_quadrature_filter #(
  parameter int SUBSAMP          = 12,
  parameter int FILT_LEN         = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int ERR_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data1,
  input  logic                 data2,
  input  logic                 enable,
  input  logic                 err_clear,
  output logic                 a_filt,
  output logic                 b_filt,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam int CNT_W = $clog2(FILT_LEN);
  localparam int PH_W  = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [PH_W-1:0] PH_MAX = PH_W'(STEPS_PER_DETENT - 1);
  localparam logic signed [PH_W-1:0] PH_MIN = -PH_MAX;
  localparam logic signed [PH_W-1:0] PH_ONE = PH_W'(1);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t                  state_reg, state_next;
  logic [SUBSAMP-1:0]      presc_reg;
  logic                    tick;
  logic [1:0]              raw;
  logic [1:0]              filt_reg, filt_next;
  logic signed [PH_W-1:0]  phase_reg, phase_next;
  logic [ERR_WIDTH-1:0]    err_reg, err_next;
  logic                    step_valid_reg, step_valid_next;
  logic                    step_dir_reg, step_dir_next;
  logic [1:0]              pos_old, pos_new, delta;

  // Bit 0 carries channel A, bit 1 channel B throughout.
  assign raw  = {data2, data1};
  assign tick = enable && (presc_reg == {SUBSAMP{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
    end else if (enable) begin
      presc_reg <= presc_reg + SUBSAMP'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             meta_reg, sync_reg;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             filt_bit_next;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          cnt_reg  <= cnt_next;
        end
      end

      // Before the first tick the level is adopted as-is; afterwards it must persist.
      always_comb begin
        filt_bit_next = filt_reg[gi];
        cnt_next      = cnt_reg;
        if (tick) begin
          if (state_reg == SYNC) begin
            filt_bit_next = sync_reg;
            cnt_next      = '0;
          end else if (sync_reg == filt_reg[gi]) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_W'(FILT_LEN - 1)) begin
            filt_bit_next = sync_reg;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt_next[gi] = filt_bit_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= SYNC;
      filt_reg       <= '0;
      phase_reg      <= '0;
      err_reg        <= '0;
      step_valid_reg <= 1'b0;
      step_dir_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      filt_reg       <= filt_next;
      phase_reg      <= phase_next;
      err_reg        <= err_next;
      step_valid_reg <= step_valid_next;
      step_dir_reg   <= step_dir_next;
    end
  end

  // Gray position around the cycle 00->10->11->01; a wrapped delta of 1 is forward.
  always_comb begin
    pos_old         = {filt_reg[1], filt_reg[0] ^ filt_reg[1]};
    pos_new         = {filt_next[1], filt_next[0] ^ filt_next[1]};
    delta           = pos_new - pos_old;
    state_next      = state_reg;
    phase_next      = phase_reg;
    err_next        = err_reg;
    step_valid_next = 1'b0;
    step_dir_next   = step_dir_reg;
    if (tick) begin
      if (state_reg == SYNC) begin
        state_next = TRACK;
        phase_next = '0;
      end else begin
        case (delta)
          2'd1: begin
            if (phase_reg == PH_MAX) begin
              phase_next      = '0;
              step_valid_next = 1'b1;
              step_dir_next   = 1'b1;
            end else begin
              phase_next = phase_reg + PH_ONE;
            end
          end
          2'd3: begin
            if (phase_reg == PH_MIN) begin
              phase_next      = '0;
              step_valid_next = 1'b1;
              step_dir_next   = 1'b0;
            end else begin
              phase_next = phase_reg - PH_ONE;
            end
          end
          2'd2: begin
            phase_next = '0;
            if (err_reg != {ERR_WIDTH{1'b1}}) begin
              err_next = err_reg + ERR_WIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
    if (err_clear) begin
      err_next = '0;
    end
  end

  assign a_filt     = filt_reg[0];
  assign b_filt     = filt_reg[1];
  assign step_valid = step_valid_reg;
  assign step_dir   = step_dir_reg;
  assign err_count  = err_reg;

endmodule

// File: tb/tb_rotary_quadrature_filter.sv
// Scoreboard bench: a tick-level behavioural model predicts filtered levels, steps
// and error counts; a negedge monitor consumes step pulses against the queue.
`timescale 1ns/1ps
module tb_rotary_quadrature_filter;

  localparam int FL  = 3;
  localparam int SPD = 4;
  localparam int EW  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          data1 = 1'b1;
  logic          data2 = 1'b1;
  logic          enable = 1'b1;
  logic          err_clear = 1'b0;
  logic          a_filt, b_filt, step_valid, step_dir;
  logic [EW-1:0] err_count;

  rotary_quadrature_filter #(
    .SUBSAMP(2), .FILT_LEN(FL), .STEPS_PER_DETENT(SPD), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data1(data1), .data2(data2),
    .enable(enable), .err_clear(err_clear), .a_filt(a_filt), .b_filt(b_filt),
    .step_valid(step_valid), .step_dir(step_dir), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit  dir;
    time t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   steps_seen = 0;

  // Behavioural model state
  bit m_synced, m_a, m_b, m_dir;
  int run_a, run_b, m_phase, m_err;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gpos(bit a, bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_synced = 0; m_a = 0; m_b = 0; m_dir = 0;
    run_a = 0; run_b = 0; m_phase = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_tick(bit a, bit b);
    bit na, nb;
    int d;
    exp_t e;
    if (!m_synced) begin
      m_a = a; m_b = b; m_synced = 1; m_phase = 0; run_a = 0; run_b = 0;
      return;
    end
    na = m_a; nb = m_b;
    if (a != m_a) begin
      run_a++;
      if (run_a == FL) begin na = a; run_a = 0; end
    end else run_a = 0;
    if (b != m_b) begin
      run_b++;
      if (run_b == FL) begin nb = b; run_b = 0; end
    end else run_b = 0;
    d = (gpos(na, nb) - gpos(m_a, m_b) + 4) % 4;
    if (d == 1) m_phase++;
    else if (d == 3) m_phase--;
    else if (d == 2) begin
      m_phase = 0;
      if (m_err < (1 << EW) - 1) m_err++;
    end
    if (m_phase == SPD || m_phase == -SPD) begin
      m_dir = (m_phase == SPD);
      m_phase = 0;
      e.dir = m_dir;
      e.t = $time;
      exp_q.push_back(e);
    end
    m_a = na; m_b = nb;
  endtask

  // One sample period: starts and ends 1 ns after a tick edge.
  task automatic do_tick(bit a, bit b, bit clr = 0);
    data1 = a; data2 = b;
    repeat (3) @(posedge clk);
    #1 err_clear = clr;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("step_missed", exp_q.size(), 0);
    model_tick(a, b);
    if (clr) m_err = 0;
    check("a_filt", a_filt, m_a);
    check("b_filt", b_filt, m_b);
    check("err_count", err_count, m_err);
    check("step_dir", step_dir, m_dir);
  endtask

  task automatic hold(bit a, bit b, int n);
    for (int i = 0; i < n; i++) do_tick(a, b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    check("rst_a_filt", a_filt, 0);
    check("rst_b_filt", b_filt, 0);
    check("rst_err", err_count, 0);
    check("rst_dir", step_dir, 0);
    check("rst_valid", step_valid, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && step_valid) begin
      steps_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL step_unexpected: got step_valid=1 dir=%0d, expected no step (t=%0t)", step_dir, $time);
      end else begin
        e = exp_q.pop_front();
        check("step_dir_pulse", step_dir, e.dir);
        check("step_latency", int'($time - e.t), 4);
      end
    end
  end

  initial begin
    int base, lvl, n, r;
    bit ca, cb;

    // 1: first tick adopts the idle level directly
    do_reset();
    do_tick(1, 1);
    check("t1_a", a_filt, 1);
    check("t1_err", err_count, 0);

    // 2: one forward detent
    data1 = 0; data2 = 0;
    do_reset();
    do_tick(0, 0);
    base = steps_seen;
    hold(1, 0, 4); hold(1, 1, 4); hold(0, 1, 4); hold(0, 0, 4);
    settle();
    check("t2_steps", steps_seen - base, 1);
    check("t2_dir", step_dir, 1);

    // 3: short glitch on A is discarded
    base = steps_seen;
    hold(1, 0, 2); hold(0, 0, 3);
    settle();
    check("t3_a", a_filt, 0);
    check("t3_steps", steps_seen - base, 0);

    // 4: reverse 3, forward 3, reverse 4
    base = steps_seen;
    hold(0, 1, 3); hold(1, 1, 3); hold(1, 0, 3);
    hold(1, 1, 3); hold(0, 1, 3); hold(0, 0, 3);
    settle();
    check("t4_no_step", steps_seen - base, 0);
    hold(0, 1, 3); hold(1, 1, 3); hold(1, 0, 3); hold(0, 0, 3);
    settle();
    check("t4_steps", steps_seen - base, 1);
    check("t4_dir", step_dir, 0);

    // enable low: inputs move but nothing downstream changes
    data1 = 1; data2 = 1; enable = 0;
    repeat (8) @(posedge clk);
    #1 enable = 1;
    check("dis_a", a_filt, 0);
    check("dis_err", err_count, 0);
    hold(0, 0, 2);

    // 5: illegal double-bit moves saturate the error counter
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) hold(1, 1, 3);
      else hold(0, 0, 3);
    end
    check("t5_sat", err_count, 255);
    do_tick(0, 0, 1);
    check("t5_clr", err_count, 0);

    // 6: reset mid-detent discards the partial phase
    hold(1, 0, 3); hold(1, 1, 3);
    do_reset();
    base = steps_seen;
    do_tick(1, 1);
    hold(0, 1, 3); hold(0, 0, 3);
    settle();
    check("t6_no_step", steps_seen - base, 0);
    check("t6_err", err_count, 0);
    hold(1, 0, 3); hold(1, 1, 3); hold(0, 1, 3); hold(0, 0, 3);
    settle();
    check("t6_steps", steps_seen - base, 1);

    // random walk with glitches and occasional illegal jumps
    ca = 0; cb = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin
        lvl = (gpos(ca, cb) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
        ca = (lvl == 1 || lvl == 2);
        cb = (lvl >= 2);
      end else begin
        ca = 1'($urandom_range(0, 1));
        cb = 1'($urandom_range(0, 1));
      end
      n = $urandom_range(1, 5);
      do_tick(ca, cb, ($urandom_range(0, 49) == 0));
      hold(ca, cb, n - 1);
    end
    do_tick(ca, cb);
    settle();
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
